// File: rtl/uart_tx_param.sv
// uart_tx_param: parametrised UART transmitter with an integrated baud divider.
//
// Frame: start bit (0), DATA_W data bits LSB first, optional parity bit,
// STOP_BITS stop bits (1). Every bit, including the start bit, lasts exactly
// CLK_DIV clock cycles measured from the accept edge.
//
// Parameters:
//   CLK_DIV   clock cycles per serial bit (2..65535)
//   DATA_W    data bits per frame (5..9)
//   PARITY    0 = none, 1 = odd, 2 = even
//   STOP_BITS 1 or 2
//
// Ports:
//   clk       system clock, rising edge
//   rst       asynchronous active-high reset
//   tx_data   word to send, sampled only on the accept edge
//   tx_valid  producer has a word
//   tx_ready  transmitter can accept a word (high only in IDLE)
//   tx        serial line, idle high
//   busy      frame in progress
//   tx_done   one-cycle pulse on the edge the final stop bit completes
module uart_tx_param #(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_W    = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic [DATA_W-1:0] tx_data,
  input  logic              tx_valid,
  output logic              tx_ready,
  output logic              tx,
  output logic              busy,
  output logic              tx_done
);

  // Elaboration-time parameter legality checks.
  generate
    if (CLK_DIV < 2 || CLK_DIV > 65535) begin : g_bad_clk_div
      $error("uart_tx_param: CLK_DIV out of range 2..65535");
    end
    if (DATA_W < 5 || DATA_W > 9) begin : g_bad_data_w
      $error("uart_tx_param: DATA_W out of range 5..9");
    end
    if (PARITY < 0 || PARITY > 2) begin : g_bad_parity
      $error("uart_tx_param: PARITY must be 0, 1 or 2");
    end
    if (STOP_BITS < 1 || STOP_BITS > 2) begin : g_bad_stop_bits
      $error("uart_tx_param: STOP_BITS must be 1 or 2");
    end
  endgenerate

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
    PAR,
    STOP
  } state_t;

  localparam logic [15:0] LAST_CNT  = 16'(CLK_DIV - 1);
  localparam logic [3:0]  LAST_IDX  = 4'(DATA_W - 1);
  localparam logic        LAST_STOP = 1'(STOP_BITS - 1);
  localparam logic        HAS_PAR   = (PARITY != 0);
  localparam logic        ODD_PAR   = (PARITY == 1);

  state_t            state;
  logic [15:0]       baud_cnt;
  logic [3:0]        bit_idx;
  logic              stop_cnt;
  logic [DATA_W-1:0] shift;
  logic              par_bit;
  logic              bit_end;

  assign bit_end = (baud_cnt == LAST_CNT);

  // tx is always loaded one edge ahead with the level of the bit that starts
  // on that edge, so the line is driven straight from a flop. The shift
  // register moves right as data bits go out; bit_idx only counts them.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      baud_cnt <= '0;
      bit_idx  <= '0;
      stop_cnt <= 1'b0;
      shift    <= '0;
      par_bit  <= 1'b0;
      tx       <= 1'b1;
      tx_ready <= 1'b1;
      busy     <= 1'b0;
      tx_done  <= 1'b0;
    end else begin
      tx_done <= 1'b0;

      if (state != IDLE) begin
        baud_cnt <= bit_end ? '0 : baud_cnt + 16'd1;
      end

      case (state)
        IDLE: begin
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          if (tx_valid) begin
            shift    <= tx_data;
            par_bit  <= ODD_PAR ? ~(^tx_data) : ^tx_data;
            baud_cnt <= '0;
            bit_idx  <= '0;
            stop_cnt <= 1'b0;
            tx       <= 1'b0;
            tx_ready <= 1'b0;
            busy     <= 1'b1;
            state    <= START;
          end
        end

        START: begin
          if (bit_end) begin
            bit_idx <= '0;
            tx      <= shift[0];
            shift   <= shift >> 1;
            state   <= DATA;
          end
        end

        DATA: begin
          if (bit_end) begin
            if (bit_idx == LAST_IDX) begin
              if (HAS_PAR) begin
                tx    <= par_bit;
                state <= PAR;
              end else begin
                tx    <= 1'b1;
                state <= STOP;
              end
            end else begin
              bit_idx <= bit_idx + 4'd1;
              tx      <= shift[0];
              shift   <= shift >> 1;
            end
          end
        end

        PAR: begin
          if (bit_end) begin
            tx    <= 1'b1;
            state <= STOP;
          end
        end

        STOP: begin
          if (bit_end) begin
            if (stop_cnt == LAST_STOP) begin
              tx       <= 1'b1;
              tx_ready <= 1'b1;
              busy     <= 1'b0;
              tx_done  <= 1'b1;
              state    <= IDLE;
            end else begin
              stop_cnt <= 1'b1;
            end
          end
        end

        default: begin
          baud_cnt <= '0;
          tx       <= 1'b1;
          tx_ready <= 1'b1;
          busy     <= 1'b0;
          state    <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_param.sv
// Directed testbench for uart_tx_param. Four instances cover 8N1, 8E1, 8O1
// (CLK_DIV=4) and 7N2 (CLK_DIV=3); frames are checked cycle by cycle against
// hand-computed bit patterns (bit k of a pattern is the k-th bit on the line).
module tb_uart_tx_param;

  logic       clk = 1'b0;
  logic       rst;
  logic [3:0] valid_a;
  logic [3:0] tx_a;
  logic [3:0] rdy_a;
  logic [3:0] busy_a;
  logic [3:0] done_a;
  logic [7:0] data_a [4];

  int n_checks = 0;
  int n_fail   = 0;

  always #5 clk = ~clk;

  uart_tx_param #(.CLK_DIV(4), .DATA_W(8), .PARITY(0), .STOP_BITS(1)) u_8n1 (
    .clk(clk), .rst(rst), .tx_data(data_a[0]), .tx_valid(valid_a[0]),
    .tx_ready(rdy_a[0]), .tx(tx_a[0]), .busy(busy_a[0]), .tx_done(done_a[0]));

  uart_tx_param #(.CLK_DIV(4), .DATA_W(8), .PARITY(2), .STOP_BITS(1)) u_8e1 (
    .clk(clk), .rst(rst), .tx_data(data_a[1]), .tx_valid(valid_a[1]),
    .tx_ready(rdy_a[1]), .tx(tx_a[1]), .busy(busy_a[1]), .tx_done(done_a[1]));

  uart_tx_param #(.CLK_DIV(4), .DATA_W(8), .PARITY(1), .STOP_BITS(1)) u_8o1 (
    .clk(clk), .rst(rst), .tx_data(data_a[2]), .tx_valid(valid_a[2]),
    .tx_ready(rdy_a[2]), .tx(tx_a[2]), .busy(busy_a[2]), .tx_done(done_a[2]));

  uart_tx_param #(.CLK_DIV(3), .DATA_W(7), .PARITY(0), .STOP_BITS(2)) u_7n2 (
    .clk(clk), .rst(rst), .tx_data(data_a[3][6:0]), .tx_valid(valid_a[3]),
    .tx_ready(rdy_a[3]), .tx(tx_a[3]), .busy(busy_a[3]), .tx_done(done_a[3]));

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // Present a word at a falling edge; returns 1 time unit after the accept edge.
  task automatic accept(input int i, input logic [7:0] d, input bit hold);
    @(negedge clk);
    data_a[i]  = d;
    valid_a[i] = 1'b1;
    @(posedge clk);
    #1;
    if (!hold) valid_a[i] = 1'b0;
  endtask

  // Called 1 time unit after the accept edge; returns 1 time unit after the
  // tx_done edge.
  task automatic run_frame(input int i, input int div, input int nbits,
                           input logic [15:0] pat, input string tag);
    for (int k = 0; k < div * nbits; k++) begin
      check($sformatf("%s tx c%0d", tag, k), tx_a[i], pat[k / div]);
      check($sformatf("%s rdy c%0d", tag, k), rdy_a[i], 0);
      check($sformatf("%s busy c%0d", tag, k), busy_a[i], 1);
      check($sformatf("%s done c%0d", tag, k), done_a[i], 0);
      @(posedge clk);
      #1;
    end
    check({tag, " done end"}, done_a[i], 1);
    check({tag, " rdy end"}, rdy_a[i], 1);
    check({tag, " busy end"}, busy_a[i], 0);
    check({tag, " tx end"}, tx_a[i], 1);
  endtask

  task automatic after_frame(input int i, input string tag);
    @(posedge clk);
    #1;
    check({tag, " done single"}, done_a[i], 0);
    check({tag, " idle tx"}, tx_a[i], 1);
    check({tag, " idle rdy"}, rdy_a[i], 1);
  endtask

  initial begin
    bit saw_done;
    rst     = 1'b1;
    valid_a = '0;
    for (int i = 0; i < 4; i++) data_a[i] = '0;

    #12;
    for (int i = 0; i < 4; i++) begin
      check($sformatf("reset tx %0d", i), tx_a[i], 1);
      check($sformatf("reset rdy %0d", i), rdy_a[i], 1);
      check($sformatf("reset busy %0d", i), busy_a[i], 0);
      check($sformatf("reset done %0d", i), done_a[i], 0);
    end
    @(negedge clk);
    rst = 1'b0;

    // 8N1 0xA5: 0,1,0,1,0,0,1,0,1,1
    accept(0, 8'hA5, 1'b0);
    run_frame(0, 4, 10, 16'b11_0100_1010, "8n1 A5");
    after_frame(0, "8n1 A5");

    // 8E1 0xA5: parity 0; 8O1 0xA5: parity 1
    accept(1, 8'hA5, 1'b0);
    run_frame(1, 4, 11, 16'b101_0100_1010, "8e1 A5");
    after_frame(1, "8e1 A5");
    accept(2, 8'hA5, 1'b0);
    run_frame(2, 4, 11, 16'b111_0100_1010, "8o1 A5");
    after_frame(2, "8o1 A5");

    // 7N2 0x41: 0,1,0,0,0,0,0,1,1,1 at 3 cycles per bit
    accept(3, 8'h41, 1'b0);
    run_frame(3, 3, 10, 16'b11_1000_0010, "7n2 41");
    after_frame(3, "7n2 41");

    // Back-to-back with tx_valid held: 0x00 then 0xFF
    accept(0, 8'h00, 1'b1);
    data_a[0] = 8'hFF;
    run_frame(0, 4, 10, 16'b10_0000_0000, "b2b 00");
    @(posedge clk);
    #1;
    valid_a[0] = 1'b0;
    run_frame(0, 4, 10, 16'b11_1111_1110, "b2b FF");
    after_frame(0, "b2b FF");
    check("b2b no third", busy_a[0], 0);

    // Reset during data bit 2 (4th bit on the line)
    accept(0, 8'hA5, 1'b0);
    for (int k = 0; k < 13; k++) begin
      check($sformatf("rst pre tx c%0d", k), tx_a[0], (16'b11_0100_1010 >> (k / 4)) & 1);
      @(posedge clk);
      #1;
    end
    rst = 1'b1;
    #1;
    check("midrst tx", tx_a[0], 1);
    check("midrst rdy", rdy_a[0], 1);
    check("midrst busy", busy_a[0], 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    saw_done = 1'b0;
    repeat (45) begin
      @(posedge clk);
      #1;
      if (done_a[0] || !tx_a[0]) saw_done = 1'b1;
    end
    check("midrst no done or frame", saw_done, 0);
    accept(0, 8'h3C, 1'b0);
    run_frame(0, 4, 10, 16'b10_0111_1000, "post rst 3C");
    after_frame(0, "post rst 3C");

    // Input noise while busy: frame must carry 0x5A latched at accept
    accept(0, 8'h5A, 1'b0);
    fork
      run_frame(0, 4, 10, 16'b10_1011_0100, "noise 5A");
      begin
        for (int j = 0; j < 30; j++) begin
          @(negedge clk);
          data_a[0]  = 8'(j * 37);
          valid_a[0] = j[0];
        end
        @(negedge clk);
        valid_a[0] = 1'b0;
      end
    join
    after_frame(0, "noise 5A");
    check("noise no extra accept", busy_a[0], 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
